// File: rtl/div_32_seq.sv
// div_32_seq: multi-cycle restoring divider producing one quotient bit per clock.
// Optional feature: define DIV_SIGNED_EN to add the snu port (two's complement division).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         request, accepted when not busy (idle or in the done cycle)
//   a, b          dividend / divisor, captured on an accepted start
//   snu           signed-not-unsigned select, captured with the operands (DIV_SIGNED_EN only)
//   q, r          quotient / remainder, held until the next result is written
//   busy          high while iterating
//   done          one-cycle pulse, q/r/dz valid in that cycle
//   dz            divide-by-zero flag, cleared by the next accepted start
module div_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_SIGNED_EN
    input  logic             snu,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc, shreg, dvs, acc_nx, sh_nx, a_mag, b_mag;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH+1:0] trial;
    logic [CW-1:0] cnt;
    logic sgn, neg_q, neg_r, accept, bz, last, ge;
`ifdef DIV_SIGNED_EN
    assign sgn = snu;
`else
    assign sgn = 1'b0;
`endif
    always_comb begin
        accept = start && state != RUN;
        bz = b == '0;
        last = cnt == CW'(1);
        a_mag = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn && b[WIDTH-1]) ? -b : b;
        // shifted remainder needs WIDTH+1 bits when the divisor MSB is set; the extra top bit keeps the borrow
        rem_sh = {acc, shreg[WIDTH-1]};
        trial = {1'b0, rem_sh} - {2'b00, dvs};
        // a non-negative trial is always below the divisor, so both top bits are clear
        ge = trial[WIDTH+1:WIDTH] == 2'b00;
        acc_nx = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        sh_nx = {shreg[WIDTH-2:0], ge};
        state_nx = accept ? (bz ? FIN : RUN) : state == RUN ? (last ? FIN : RUN) : IDLE;
        busy = state == RUN;
        done = state == FIN;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            shreg <= '0;
            dvs <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q <= '0;
            r <= '0;
            dz <= 1'b0;
        end else if (accept) begin
            acc <= '0;
            shreg <= a_mag;
            dvs <= b_mag;
            cnt <= CW'(WIDTH);
            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn && a[WIDTH-1];
            dz <= bz;
            if (bz) begin
                q <= '1;
                r <= a;
            end
        end else if (state == RUN) begin
            acc <= acc_nx;
            shreg <= sh_nx;
            cnt <= cnt - 1'b1;
            // sign fix-up folded into the final iteration keeps latency identical to unsigned
            if (last) begin
                q <= neg_q ? -sh_nx : sh_nx;
                r <= neg_r ? -acc_nx : acc_nx;
            end
        end
    end
endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: randomized self-checking bench for div_32_seq against an arithmetic model.
module tb_div_32_seq;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, snu = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] q, r;
    logic busy, done, dz;
    int cycle = 0, t0 = 0, pass_cnt = 0, total = 0;

    div_32_seq dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
`ifdef DIV_SIGNED_EN
        .snu(snu),
`endif
        .q(q),
        .r(r),
        .busy(busy),
        .done(done),
        .dz(dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        a = av;
        b = bv;
        snu = sv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cycle;
        a = $urandom;
        b = $urandom;
        snu = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                lat = cycle - t0 + 1;
                return;
            end
        end
    endtask

    task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         output logic [31:0] eq, output logic [31:0] er, output logic ed);
        ed = bv == 0;
        if (bv == 0) begin
            eq = '1;
            er = av;
        end else if (sv && av == 32'h80000000 && bv == 32'hFFFFFFFF) begin
            eq = av;
            er = '0;
        end else if (sv) begin
            eq = $signed(av) / $signed(bv);
            er = $signed(av) % $signed(bv);
        end else begin
            eq = av / bv;
            er = av % bv;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (q !== 32'd0) $display("FAIL reset_q: got %0h expected 0", q); else pass_cnt++;
        total++; if (r !== 32'd0) $display("FAIL reset_r: got %0h expected 0", r); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total++; if (dz !== 1'b0) $display("FAIL reset_dz: got %b expected 0", dz); else pass_cnt++;
    endtask

    task automatic test_basic;
        int lat, bc;
        start_op(32'd100, 32'd7, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 33) $display("FAIL basic_latency: got %0d expected 33", lat); else pass_cnt++;
        total++; if (bc !== 32) $display("FAIL basic_busy_cycles: got %0d expected 32", bc); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else pass_cnt++;
        total++; if (q !== 32'd14) $display("FAIL basic_q: got %0d expected 14", q); else pass_cnt++;
        total++; if (r !== 32'd2) $display("FAIL basic_r: got %0d expected 2", r); else pass_cnt++;
        total++; if (dz !== 1'b0) $display("FAIL basic_dz: got %b expected 0", dz); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else pass_cnt++;
        total++; if (q !== 32'd14) $display("FAIL basic_q_hold: got %0d expected 14", q); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int d1 = 0, d2 = 0;
        logic [31:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
        a = 32'd2;
        b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cycle;
        a = 32'hFFFFFFFF;
        b = 32'd1;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (done && d1 == 0) begin d1 = c; q1 = q; r1 = r; end
            else if (done && d2 == 0) begin d2 = c; q2 = q; r2 = r; end
            @(posedge clk);
            #1;
            if (c == 33) start = 1'b0;
        end
        total++; if (d1 !== 33) $display("FAIL b2b_first_cycle: got %0d expected 33", d1); else pass_cnt++;
        total++; if (q1 !== 32'd0) $display("FAIL b2b_first_q: got %0h expected 0", q1); else pass_cnt++;
        total++; if (r1 !== 32'd2) $display("FAIL b2b_first_r: got %0h expected 2", r1); else pass_cnt++;
        total++; if (d2 !== 66) $display("FAIL b2b_second_cycle: got %0d expected 66", d2); else pass_cnt++;
        total++; if (q2 !== 32'hFFFFFFFF) $display("FAIL b2b_second_q: got %0h expected ffffffff", q2); else pass_cnt++;
        total++; if (r2 !== 32'd0) $display("FAIL b2b_second_r: got %0h expected 0", r2); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int lat, bc;
        start_op(32'd5, 32'd0, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 1) $display("FAIL dz_latency: got %0d expected 1", lat); else pass_cnt++;
        total++; if (bc !== 0) $display("FAIL dz_busy: got %0d busy cycles expected 0", bc); else pass_cnt++;
        total++; if (dz !== 1'b1) $display("FAIL dz_flag: got %b expected 1", dz); else pass_cnt++;
        total++; if (q !== 32'hFFFFFFFF) $display("FAIL dz_q: got %0h expected ffffffff", q); else pass_cnt++;
        total++; if (r !== 32'd5) $display("FAIL dz_r: got %0h expected 5", r); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL dz_done_pulse: got %b expected 0", done); else pass_cnt++;
        total++; if (dz !== 1'b1) $display("FAIL dz_hold: got %b expected 1", dz); else pass_cnt++;
        start_op(32'd20, 32'd6, 1'b0);
        @(negedge clk);
        total++; if (dz !== 1'b0) $display("FAIL dz_clear_on_start: got %b expected 0", dz); else pass_cnt++;
        wait_done(lat, bc);
        total++; if (lat !== 33) $display("FAIL dz_next_latency: got %0d expected 33", lat); else pass_cnt++;
        total++; if (q !== 32'd3 || r !== 32'd2) $display("FAIL dz_next_result: got q=%0d r=%0d expected q=3 r=2", q, r); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int lat, bc, extra = 0;
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        total++; if (lat !== 33) $display("FAIL ignore_latency: got %0d expected 33", lat); else pass_cnt++;
        total++; if (q !== 32'd333) $display("FAIL ignore_q: got %0d expected 333", q); else pass_cnt++;
        total++; if (r !== 32'd1) $display("FAIL ignore_r: got %0d expected 1", r); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) $display("FAIL ignore_not_queued: got %0d active cycles expected 0", extra); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat, bc, extra = 0;
        start_op(32'd500, 32'd4, 1'b0);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) $display("FAIL midrst_flags: got busy=%b done=%b dz=%b expected 0 0 0", busy, done, dz); else pass_cnt++;
        total++; if (q !== 32'd0 || r !== 32'd0) $display("FAIL midrst_qr: got q=%0h r=%0h expected 0 0", q, r); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", extra); else pass_cnt++;
        start_op(32'd9, 32'd2, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 33) $display("FAIL midrst_latency: got %0d expected 33", lat); else pass_cnt++;
        total++; if (q !== 32'd4 || r !== 32'd1) $display("FAIL midrst_result: got q=%0d r=%0d expected q=4 r=1", q, r); else pass_cnt++;
    endtask

    task automatic test_random;
        int lat, bc;
        logic [31:0] av, bv, eq, er;
        logic ed;
        for (int i = 0; i < 24; i++) begin
            av = $urandom;
            case (i % 4)
                0: bv = $urandom_range(1, 255);
                1: bv = $urandom;
                2: bv = $urandom | 32'h80000000;
                default: bv = (i % 8 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            model(av, bv, 1'b0, eq, er, ed);
            start_op(av, bv, 1'b0);
            wait_done(lat, bc);
            total++; if (lat !== (ed ? 1 : 33)) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, ed ? 1 : 33); else pass_cnt++;
            total++; if (q !== eq) $display("FAIL rand_q[%0d]: a=%0h b=%0h got %0h expected %0h", i, av, bv, q, eq); else pass_cnt++;
            total++; if (r !== er) $display("FAIL rand_r[%0d]: a=%0h b=%0h got %0h expected %0h", i, av, bv, r, er); else pass_cnt++;
            total++; if (dz !== ed) $display("FAIL rand_dz[%0d]: got %b expected %b", i, dz, ed); else pass_cnt++;
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int lat, bc;
        logic [31:0] av, bv, eq, er;
        logic ed;
        logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFF9C};
        logic [31:0] tb [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 16; i++) begin
            av = (i < 4) ? ta[i] : $urandom;
            bv = (i < 4) ? tb[i] : ($urandom >> $urandom_range(0, 31)) | 32'd1;
            if (i >= 4 && i % 2 == 0) bv = -bv;
            model(av, bv, 1'b1, eq, er, ed);
            start_op(av, bv, 1'b1);
            wait_done(lat, bc);
            total++; if (lat !== (ed ? 1 : 33)) $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, ed ? 1 : 33); else pass_cnt++;
            total++; if (q !== eq) $display("FAIL signed_q[%0d]: a=%0h b=%0h got %0h expected %0h", i, av, bv, q, eq); else pass_cnt++;
            total++; if (r !== er) $display("FAIL signed_r[%0d]: a=%0h b=%0h got %0h expected %0h", i, av, bv, r, er); else pass_cnt++;
            total++; if (dz !== ed) $display("FAIL signed_dz[%0d]: got %b expected %b", i, dz, ed); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_div_zero;
        test_ignore_start;
        test_reset_mid;
        test_random;
`ifdef DIV_SIGNED_EN
        test_signed;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/div_32_seq.md
# div_32_seq

Multi-cycle 32-bit restoring divider that uses the same subtract/compare datapath as the ripple-carry add/sub unit and is its inverse-operation counterpart in the arithmetic section. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the add/sub unit and the multiplier behind the ALU's multi-cycle operation port.

## Interface
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- A  input  WIDTH  dividend, captured on accepted START.
- B  input  WIDTH  divisor, captured on accepted START.
- Q  output  WIDTH  quotient; holds until the next accepted START.
- R  output  WIDTH  remainder; holds until the next accepted START.
- BUSY  output  1  high while iterating.
- DONE  output  1  one-cycle pulse; Q/R/DZ valid in that cycle and held afterwards.
- DZ  output  1  divide-by-zero flag, valid with DONE.
- SnU  input  1  signed-not-unsigned select; present only with DIV_SIGNED_EN.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, START=1 and B≠0:
  - load remainder accumulator = 0, shift register = A, divisor register = B, counter = WIDTH.
  - go to RUN.
- IDLE, START=1 and B=0:
  - go straight to FIN.
  - Q = all ones, R = A, DZ = 1.
- RUN, each cycle:
  - shift {acc, shreg} left by 1.
  - trial = acc − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: acc = trial, and shreg LSB = 1.
  - Otherwise: acc is unchanged, and shreg LSB = 0.
  - Decrement counter; on reaching 0, go to FIN.
- FIN, one cycle:
  - Q = shreg, R = acc, DONE = 1, BUSY = 0.
  - Next state is IDLE.
  - FIN accepts START exactly like IDLE, giving back-to-back operation.
- START while in RUN is ignored; it is neither queued nor an error.
- A and B are sampled only on acceptance. Later changes do not affect the operation in progress.
- Arithmetic is unsigned by default. A WIDTH+1 bit subtract prevents loss of the borrow when the divisor MSB is set.
- RST in any state, including mid-RUN:
  - next cycle is IDLE, BUSY=0, DONE=0, DZ=0, Q=0, R=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: Q=0, R=0, BUSY=0, DONE=0, DZ=0, state IDLE.
- Accepted START at edge 0:
  - BUSY=1 from cycle 1 through cycle WIDTH.
  - DONE=1 in cycle WIDTH+1, i.e. 33 cycles of latency for WIDTH=32.
- Divide by zero: DONE=1 and DZ=1 in cycle 1 (latency 1); BUSY is never asserted.
- DZ is cleared on the next accepted START.
- DONE is never high for two consecutive cycles unless a START is accepted in FIN and that operation is itself divide-by-zero.
- Back-to-back operation: START held high yields one result every WIDTH+1 cycles.

## Configuration
- DIV_SIGNED_EN defined:
  - Adds the SnU input.
  - With SnU=1:
    - operands are two's complement and their magnitudes are divided.
    - quotient truncates toward zero; quotient is negated if the operand signs differ.
    - remainder takes the sign of the dividend.
    - sign fix-up happens in the FIN transition, so latency is unchanged.
  - With SnU=1 and B=0: Q = −1 (all ones), R = A, DZ=1.
  - With SnU=1, the most-negative dividend and B=−1: Q = most-negative value, R=0, DZ=0.
  - SnU is captured with the operands.
- DIV_SIGNED_EN undefined:
  - No SnU port; unsigned only, as described above.

## Test plan
- A=100, B=7, START pulse -> DONE in cycle 33, Q=14, R=2, DZ=0; BUSY high for cycles 1–32.
- A=2, B=5, then A=32'hFFFFFFFF, B=1, back-to-back with START held -> Q=0, R=2 at cycle 33; Q=32'hFFFFFFFF, R=0 at cycle 66.
- A=5, B=0 -> DONE and DZ in cycle 1, Q=32'hFFFFFFFF, R=5; BUSY never asserted.
- A=1000, B=3, START re-pulsed with A=9, B=9 at cycle 10 -> second START ignored; Q=333, R=1 at cycle 33.
- A=500, B=4, RST asserted at cycle 15 -> from cycle 16: IDLE, all outputs 0, no DONE pulse; a new START with A=9, B=2 gives Q=4, R=1 at 33 cycles of latency.
- With DIV_SIGNED_EN, SnU=1:
  - A=−7, B=2 -> Q=−3, R=−1.
  - A=7, B=−2 -> Q=−3, R=1.
  - A=32'h80000000, B=−1 -> Q=32'h80000000, R=0.
